div_unit: RTL and testbench

- Iterative multi-cycle integer divider for the 64-bit core, covering RV64M DIV/DIVU/REM/REMU and the word forms DIVW/DIVUW/REMW/REMUW.
- Takes operands straight from the register file read ports (rd1 -> a, rd2 -> b) and drives the register file write port (wb_we/wb_addr/result -> we/wa/wd) when finished.
- Core stalls on busy.

---
 rtl/div_unit.sv | 134 +++++++++++++
 tb/tb_div_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and W forms; writes back to the register file.
// Latency 66 cycles (64-bit) / 34 (word) / 1 (div-by-zero, signed overflow); busy holds while occupied, so the core stalls.
module div_unit #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic              word,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic [ADDR_W-1:0] wb_addr,
    output logic              wb_we
);
    localparam int HALF  = 32;
    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

    state_t             state, state_nxt;
    logic               sel_rem, word_q, q_neg, r_neg;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  divisor, rem, quo;

    // Operand preparation, evaluated combinationally on the request inputs
    logic              signed_op, a_neg, b_neg, b_zero, ovf, special;
    logic [DATA_W-1:0] a_ext, b_ext, a_sx, a_mag, b_mag, a_min, spec_quo, spec_rem, spec_res;

    always_comb begin
        signed_op = ~op[0];
        a_sx      = word ? {{(DATA_W-HALF){a[HALF-1]}}, a[HALF-1:0]} : a;
        if (word) begin
            a_ext = signed_op ? a_sx : {{(DATA_W-HALF){1'b0}}, a[HALF-1:0]};
            b_ext = signed_op ? {{(DATA_W-HALF){b[HALF-1]}}, b[HALF-1:0]}
                              : {{(DATA_W-HALF){1'b0}}, b[HALF-1:0]};
            a_min = {{(DATA_W-HALF+1){1'b1}}, {(HALF-1){1'b0}}};
        end else begin
            a_ext = a;
            b_ext = b;
            a_min = {1'b1, {(DATA_W-1){1'b0}}};
        end
        a_neg    = signed_op & a_ext[DATA_W-1];
        b_neg    = signed_op & b_ext[DATA_W-1];
        a_mag    = a_neg ? -a_ext : a_ext;
        b_mag    = b_neg ? -b_ext : b_ext;
        b_zero   = (b_ext == '0);
        ovf      = signed_op & (a_ext == a_min) & (b_ext == '1);
        special  = b_zero | ovf;
        spec_quo = b_zero ? '1 : a_ext;
        spec_rem = b_zero ? a_sx : '0;
        spec_res = op[1] ? spec_rem : spec_quo;
    end

    // One restoring step: shift in the next dividend bit, subtract if it fits
    logic [DATA_W:0]   sh, diff;
    logic              fits;
    logic [DATA_W-1:0] rem_nxt;

    always_comb begin
        sh      = {rem, quo[DATA_W-1]};
        diff    = sh - {1'b0, divisor};
        fits    = ~diff[DATA_W];
        rem_nxt = fits ? diff[DATA_W-1:0] : sh[DATA_W-1:0];
    end

    logic [DATA_W-1:0] q_fix, r_fix, sel, fix_res;

    always_comb begin
        q_fix   = q_neg ? -quo : quo;
        r_fix   = r_neg ? -rem : rem;
        sel     = sel_rem ? r_fix : q_fix;
        fix_res = word_q ? {{(DATA_W-HALF){sel[HALF-1]}}, sel[HALF-1:0]} : sel;
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        done      = (state == DONE);
        wb_we     = done && (wb_addr != '0);
        case (state)
            IDLE:    if (start) state_nxt = special ? DONE : ITER;
            ITER:    if (cnt == '0) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sel_rem <= 1'b0;
            word_q  <= 1'b0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            cnt     <= '0;
            divisor <= '0;
            rem     <= '0;
            quo     <= '0;
            result  <= '0;
            wb_addr <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (start) begin
                    sel_rem <= op[1];
                    word_q  <= word;
                    wb_addr <= rd_addr;
                    q_neg   <= a_neg ^ b_neg;
                    r_neg   <= a_neg;
                    divisor <= b_mag;
                    rem     <= '0;
                    // Word dividends are pre-aligned to the top so the same shifter serves both widths
                    quo     <= word ? {a_mag[HALF-1:0], {(DATA_W-HALF){1'b0}}} : a_mag;
                    cnt     <= word ? CNT_W'(HALF-1) : CNT_W'(DATA_W-1);
                    if (special) result <= spec_res;
                end
                ITER: begin
                    rem <= rem_nxt;
                    quo <= {quo[DATA_W-2:0], fits};
                    cnt <= cnt - CNT_W'(1);
                end
                FIX:     result <= fix_res;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: expected results are queued at issue and checked when done pulses.
module tb_div_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic        word = 1'b0;
    logic [63:0] a = '0, b = '0;
    logic [4:0]  rd_addr = '0;
    logic        busy, done, wb_we;
    logic [63:0] result;
    logic [4:0]  wb_addr;

    div_unit #(.DATA_W(64), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .word(word), .a(a), .b(b),
        .rd_addr(rd_addr), .busy(busy), .done(done), .result(result),
        .wb_addr(wb_addr), .wb_we(wb_we)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        logic [4:0]  addr;
        int          lat;
    } exp_t;

    typedef struct packed {
        logic [1:0]  o;
        logic        w;
        logic [63:0] x;
        logic [63:0] y;
        logic [4:0]  rd;
    } vec_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad = 0;

    function automatic logic [63:0] model(input logic [1:0] o, input logic w,
                                          input logic [63:0] x, input logic [63:0] y);
        logic [63:0] sa, sb, ua, ub, q, r, s;
        sa = w ? {{32{x[31]}}, x[31:0]} : x;
        sb = w ? {{32{y[31]}}, y[31:0]} : y;
        ua = w ? {32'b0, x[31:0]} : x;
        ub = w ? {32'b0, y[31:0]} : y;
        if (!o[0]) begin
            if (sb == '0) begin
                q = '1; r = sa;
            end else if (sb == '1 && sa == (w ? 64'hFFFFFFFF80000000 : 64'h8000000000000000)) begin
                q = sa; r = '0;
            end else begin
                q = $signed(sa) / $signed(sb);
                r = $signed(sa) % $signed(sb);
            end
        end else begin
            if (ub == '0) begin
                q = '1; r = sa;
            end else begin
                q = ua / ub;
                r = ua % ub;
            end
        end
        s = o[1] ? r : q;
        return w ? {{32{s[31]}}, s[31:0]} : s;
    endfunction

    function automatic int model_lat(input logic [1:0] o, input logic w,
                                     input logic [63:0] x, input logic [63:0] y);
        logic zero, ovf;
        zero = w ? (y[31:0] == 32'h0) : (y == 64'h0);
        ovf  = !o[0] && (w ? (x[31:0] == 32'h80000000 && y[31:0] == 32'hFFFFFFFF)
                           : (x == 64'h8000000000000000 && y == '1));
        return (zero || ovf) ? 1 : (w ? 34 : 66);
    endfunction

    // Drives start for one cycle (cycle 0); returns 1 time unit into cycle 1.
    task automatic issue(input logic [1:0] o, input logic w, input logic [63:0] x,
                         input logic [63:0] y, input logic [4:0] rd, input bit push);
        exp_t e;
        @(posedge clk); #1;
        start = 1'b1; op = o; word = w; a = x; b = y; rd_addr = rd;
        if (push) begin
            e.res  = model(o, w, x, y);
            e.addr = rd;
            e.lat  = model_lat(o, w, x, y);
            sb_q.push_back(e);
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Samples on falling edges starting with cycle 1; lat is the cycle index where done was seen.
    task automatic wait_done(output int lat, output bit ok);
        ok = 1'b0;
        lat = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b0)    begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0)    begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (wb_we !== 1'b0)   begin bad++; $display("FAIL reset_wb_we got=%b want=0", wb_we); end
        total++; if (result !== 64'h0) begin bad++; $display("FAIL reset_result got=%h want=0", result); end
        total++; if (wb_addr !== 5'h0) begin bad++; $display("FAIL reset_wb_addr got=%h want=0", wb_addr); end
    endtask

    task automatic test_divu_timing();
        exp_t e;
        issue(2'b01, 1'b0, 64'd100, 64'd7, 5'd5, 1'b1);
        for (int c = 1; c <= 67; c++) begin
            @(negedge clk);
            total++; if (busy !== (c <= 66)) begin bad++; $display("FAIL divu_busy cycle=%0d got=%b want=%b", c, busy, c <= 66); end
            total++; if (done !== (c == 66)) begin bad++; $display("FAIL divu_done cycle=%0d got=%b want=%b", c, done, c == 66); end
            total++; if (wb_we !== (c == 66)) begin bad++; $display("FAIL divu_wb_we cycle=%0d got=%b want=%b", c, wb_we, c == 66); end
            if (c == 66 && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                total++; if (result !== e.res)   begin bad++; $display("FAIL divu_result got=%h want=%h", result, e.res); end
                total++; if (wb_addr !== e.addr) begin bad++; $display("FAIL divu_wb_addr got=%h want=%h", wb_addr, e.addr); end
            end
        end
        sb_q.delete();
    endtask

    task automatic test_ops();
        vec_t tv[14];
        exp_t e;
        int   lat;
        bit   ok;
        tv[0]  = {2'd2, 1'b0, 64'hFFFFFFFFFFFFFFF9, 64'd2, 5'd3};                 // REM -7/2
        tv[1]  = {2'd0, 1'b0, 64'hFFFFFFFFFFFFFFF9, 64'd2, 5'd4};                 // DIV -7/2
        tv[2]  = {2'd0, 1'b0, 64'd42, 64'd0, 5'd6};                               // DIV by zero
        tv[3]  = {2'd3, 1'b0, 64'd42, 64'd0, 5'd7};                               // REMU by zero
        tv[4]  = {2'd0, 1'b0, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 5'd8};  // DIV overflow
        tv[5]  = {2'd2, 1'b0, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 5'd9};  // REM overflow
        tv[6]  = {2'd1, 1'b1, 64'h00000000FFFFFFFE, 64'd1, 5'd10};                // DIVUW
        tv[7]  = {2'd2, 1'b1, 64'h0000000100000007, 64'hFFFFFFFFFFFFFFFE, 5'd11}; // REMW
        tv[8]  = {2'd0, 1'b1, 64'h1234567880000000, 64'h00000000FFFFFFFF, 5'd12}; // DIVW overflow
        tv[9]  = {2'd3, 1'b1, 64'h0000000080000005, 64'hABCD000000000000, 5'd13}; // REMUW by zero
        tv[10] = {2'd2, 1'b0, 64'd7, 64'hFFFFFFFFFFFFFFFE, 5'd14};                // REM 7/-2
        tv[11] = {2'd0, 1'b0, 64'h8000000000000000, 64'd3, 5'd15};                // DIV min/3
        tv[12] = {2'd1, 1'b0, {$urandom, $urandom}, {32'h0, $urandom}, 5'd16};
        tv[13] = {2'd3, 1'b0, {$urandom, $urandom}, {16'h0, $urandom, 16'h0}, 5'd17};
        for (int i = 0; i < 14; i++) begin
            issue(tv[i].o, tv[i].w, tv[i].x, tv[i].y, tv[i].rd, 1'b1);
            wait_done(lat, ok);
            e = sb_q.pop_front();
            total++;
            if (!ok) begin
                bad++; $display("FAIL ops_timeout vec=%0d got=no_done want=done", i);
                continue;
            end
            if (lat !== e.lat)   begin bad++; $display("FAIL ops_latency vec=%0d got=%0d want=%0d", i, lat, e.lat); end
            total++; if (result !== e.res)   begin bad++; $display("FAIL ops_result vec=%0d got=%h want=%h", i, result, e.res); end
            total++; if (wb_addr !== e.addr) begin bad++; $display("FAIL ops_wb_addr vec=%0d got=%h want=%h", i, wb_addr, e.addr); end
            total++; if (wb_we !== 1'b1)     begin bad++; $display("FAIL ops_wb_we vec=%0d got=%b want=1", i, wb_we); end
        end
    endtask

    task automatic test_ignore_and_reset();
        exp_t e;
        int   lat;
        bit   ok;
        issue(2'b01, 1'b0, 64'd100, 64'd7, 5'd5, 1'b0);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL ign_busy cycle=%0d got=%b want=1", c, busy); end
            total++; if (done !== 1'b0) begin bad++; $display("FAIL ign_done cycle=%0d got=%b want=0", c, done); end
            if (c == 9) begin
                @(posedge clk); #1;
                start = 1'b1; op = 2'b00; a = 64'd42; b = 64'd0; rd_addr = 5'd1;
            end else if (c == 10) begin
                @(posedge clk); #1 start = 1'b0;
            end else if (c == 19) begin
                @(posedge clk); #1 rst = 1'b1;
            end else if (c == 20) begin
                @(posedge clk); #1 rst = 1'b0;
            end
        end
        @(negedge clk);
        total++; if (busy !== 1'b0)    begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0)    begin bad++; $display("FAIL rst_done got=%b want=0", done); end
        total++; if (wb_we !== 1'b0)   begin bad++; $display("FAIL rst_wb_we got=%b want=0", wb_we); end
        total++; if (result !== 64'h0) begin bad++; $display("FAIL rst_result got=%h want=0", result); end
        total++; if (wb_addr !== 5'h0) begin bad++; $display("FAIL rst_wb_addr got=%h want=0", wb_addr); end
        issue(2'b01, 1'b0, 64'd9, 64'd3, 5'd7, 1'b1);
        wait_done(lat, ok);
        e = sb_q.pop_front();
        total++; if (!ok || lat != 66) begin bad++; $display("FAIL post_rst_latency got=%0d want=66", lat); end
        total++; if (result !== e.res) begin bad++; $display("FAIL post_rst_result got=%h want=%h", result, e.res); end
        total++; if (wb_addr !== e.addr) begin bad++; $display("FAIL post_rst_wb_addr got=%h want=%h", wb_addr, e.addr); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   lat;
        bit   ok;
        // Each issue lands in the cycle right after the previous done; rd_addr 0 never writes back.
        issue(2'b00, 1'b0, 64'd42, 64'd0, 5'd0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            wait_done(lat, ok);
            e = sb_q.pop_front();
            total++; if (!ok || lat != e.lat) begin bad++; $display("FAIL b2b_latency step=%0d got=%0d want=%0d", k, lat, e.lat); end
            total++; if (result !== e.res)    begin bad++; $display("FAIL b2b_result step=%0d got=%h want=%h", k, result, e.res); end
            total++; if (wb_we !== (e.addr != 5'd0)) begin bad++; $display("FAIL b2b_wb_we step=%0d got=%b want=%b", k, wb_we, e.addr != 5'd0); end
            if (k == 0) issue(2'b11, 1'b0, 64'd100, 64'd7, 5'd0, 1'b1);
            if (k == 1) issue(2'b00, 1'b1, 64'hFFFFFFFFFFFFFF9C, 64'd7, 5'd31, 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_divu_timing();
        test_ops();
        test_ignore_and_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
